ysyx_22041207_mul: RTL and testbench
====================================

Name: ysyx_22041207_mul

Overview:
Iterative 64x64 shift-add multiplier producing the low 64 bits of the product, i.e. the RV64 MUL result. It sits inside the ALU as a multi-cycle unit. The ALU launches an operation with a valid/ready handshake, stalls the pipeline while the unit is busy, and can abort it with a pipeline flush.

Parameters:
- XLEN, 64, operand and result width; the counter width is derived as log2(XLEN)+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mul_valid  in  1  request; operands are valid this cycle.
- flush  in  1  synchronous abort of any operation in flight.
- multiplicand  in  64  operand A.
- multiplier  in  64  operand B.
- mul_ready  out  1  high when the unit is idle and can accept a request.
- out_valid  out  1  one-cycle pulse; result is valid.
- result  out  64  low 64 bits of A*B (modulo 2^64).

Port order is positional and fixed: clk, rst, mul_valid, flush, multiplicand, multiplier, mul_ready, out_valid, result.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge): state=IDLE, mul_ready=1, out_valid=0, result=0, internal registers cleared. rst has priority over everything.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mul_ready=1.
  - If mul_valid=1 and flush=0 at an edge, latch A into a 128-bit shift register (upper half zero) and B into a 64-bit shift register, clear the accumulator, set count=0 and go to BUSY.
  - mul_ready drops to 0 on that same edge.
- BUSY, each edge:
  - If B[0]=1, accumulator += A.
  - A shifts left 1; B shifts right 1 (logical); count += 1.
  - After the edge where count reaches 64, go to DONE.
  - Exactly 64 BUSY cycles.
- DONE:
  - out_valid=1 and result = accumulator[63:0] for exactly one cycle.
  - On the next edge, return to IDLE with mul_ready=1 and out_valid=0.
  - result holds its value until the next operation completes or reset.
- Latency:
  - Accept at edge E0.
  - out_valid is high during the cycle after edge E0+64.
  - A new request can be accepted at edge E0+66 at the earliest.
- Arithmetic:
  - Unsigned accumulation truncated to 64 bits.
  - Identical bits to a signed low-half product, so MUL needs no sign handling.
  - Overflow wraps silently.
- mul_valid while BUSY or DONE is ignored; no queueing. Operand inputs are sampled only at acceptance; later changes have no effect.
- flush=1 at an edge while BUSY or DONE:
  - Return to IDLE; out_valid=0 on the next cycle.
  - Partial result is discarded; result keeps its previous completed value.
- flush=1 with mul_valid=1 in IDLE: not accepted; the unit stays IDLE.
- Simultaneous rst and flush: rst behaviour.

Optional Feature:
- MUL_EARLY_TERM_EN
- Defined:
  - In BUSY, if the remaining multiplier register is zero, go to DONE on that edge without further iterations.
  - If B=0 at acceptance, go to DONE after one BUSY cycle.
  - Latency becomes (index of highest set bit of B)+1 BUSY cycles, minimum 1.
  - Result is bit-identical to the fixed-latency version.
- Undefined: fixed 64 BUSY cycles for every operand.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> mul_ready=1, out_valid=0, result=0.
- Basic: A=3, B=5 -> out_valid pulses once, result=0xF; with the macro undefined, the pulse is exactly 65 cycles after the accept edge, and mul_ready=1 on the following cycle.
- Wrap: A=0xFFFFFFFFFFFFFFFF, B=0xFFFFFFFFFFFFFFFF -> result=0x0000000000000001. A=0x8000000000000000, B=2 -> result=0.
- Signed equivalence: A=-7 (0xFFFFFFFFFFFFFFF9), B=6 -> result=0xFFFFFFFFFFFFFFD6 (-42).
- Flush: accept A=10, B=20, assert flush 10 cycles later -> no out_valid pulse, mul_ready=1 next cycle, result unchanged. A new request A=4, B=4 then yields result=0x10.
- Busy ignore / flush-accept conflict: a second mul_valid during BUSY with different operands -> no effect; result is from the first pair. mul_valid=1 with flush=1 in IDLE -> stays IDLE, mul_ready=1.

Source files
------------

// File: rtl/ysyx_22041207_mul.sv
// ============================================================================
// ysyx_22041207_mul
// ----------------------------------------------------------------------------
// Iterative shift-add multiplier that returns the low XLEN bits of
// multiplicand * multiplier (the RV64 MUL result). It is launched with a
// valid/ready handshake, runs one partial-product step per clock, and can be
// aborted at any time by flush. The low-half product is the same for signed
// and unsigned operands, so no sign handling is needed.
//
// Optional build macro:
//   MUL_EARLY_TERM_EN - when defined, BUSY ends as soon as the remaining
//                       multiplier bits are all zero (minimum one BUSY
//                       cycle). When undefined, every operation takes exactly
//                       XLEN BUSY cycles.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (highest priority)
//   mul_valid    in   request, operands valid this cycle
//   flush        in   synchronous abort of any operation in flight
//   multiplicand in   operand A [XLEN-1:0]
//   multiplier   in   operand B [XLEN-1:0]
//   mul_ready    out  idle and able to accept a request (registered)
//   out_valid    out  one-cycle pulse, result valid (registered)
//   result       out  low XLEN bits of A*B, held until the next completion
//
// State table:
//   IDLE | waiting for a request, mul_ready=1
//   BUSY | one shift-add step per clock
//   DONE | out_valid=1 for one cycle, result updated
// ============================================================================
module ysyx_22041207_mul #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            mul_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam int             CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;

    // Only the low XLEN bits of the shifted multiplicand can ever reach the
    // truncated product, so the bits shifted out the top are simply dropped.
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_ready;
    logic            r_valid;

    logic [XLEN-1:0] w_a_nx;
    logic [XLEN-1:0] w_b_nx;
    logic [XLEN-1:0] w_acc_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [XLEN-1:0] w_result_nx;
    logic            w_ready_nx;
    logic            w_valid_nx;

    logic [XLEN-1:0] w_addend;
    logic [XLEN-1:0] w_acc_sum;
    logic [XLEN-1:0] w_b_shift;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_last;

    assign w_addend  = r_b[0] ? r_a : '0;
    assign w_acc_sum = r_acc + w_addend;
    assign w_b_shift = r_b >> 1;
    assign w_cnt_inc = r_cnt + CW'(1);

`ifdef MUL_EARLY_TERM_EN
    // No set bits left in the multiplier means no further additions.
    assign w_last = (w_cnt_inc == CNT_LAST) || (w_b_shift == '0);
`else
    assign w_last = (w_cnt_inc == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_a      <= w_a_nx;
            r_b      <= w_b_nx;
            r_acc    <= w_acc_nx;
            r_cnt    <= w_cnt_nx;
            r_result <= w_result_nx;
            r_ready  <= w_ready_nx;
            r_valid  <= w_valid_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_a_nx      = r_a;
        w_b_nx      = r_b;
        w_acc_nx    = r_acc;
        w_cnt_nx    = r_cnt;
        w_result_nx = r_result;

        unique case (r_state)
            IDLE: begin
                if (mul_valid && !flush) begin
                    w_a_nx     = multiplicand;
                    w_b_nx     = multiplier;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_state_nx = IDLE;
                end else begin
                    w_acc_nx = w_acc_sum;
                    w_a_nx   = r_a << 1;
                    w_b_nx   = w_b_shift;
                    w_cnt_nx = w_cnt_inc;
                    if (w_last) begin
                        // Publish the sum including this final step.
                        w_result_nx = w_acc_sum;
                        w_state_nx  = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        w_ready_nx = (w_state_nx == IDLE);
        w_valid_nx = (w_state_nx == DONE);
    end

    assign mul_ready = r_ready;
    assign out_valid = r_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_ysyx_22041207_mul.sv
module tb_ysyx_22041207_mul;

    logic        clk;
    logic        rst;
    logic        mul_valid;
    logic        flush;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result;

    int total;
    int bad;

    ysyx_22041207_mul #(.XLEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    // Reference: the product truncated to 64 bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        p = a * b;
        return p;
    endfunction

    // Cycles from the accept edge to the cycle carrying out_valid.
    function automatic int ref_lat(input logic [63:0] b);
`ifdef MUL_EARLY_TERM_EN
        for (int i = 63; i >= 0; i--) begin
            if (b[i]) return i + 2;
        end
        return 2;
`else
        return 65;
`endif
    endfunction

    // Launch one operation and wait (bounded) for its completion pulse.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input string nm);
        int cyc;
        check({nm, "_ready_pre"}, {63'd0, mul_ready}, 64'd1);
        mul_valid    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        @(negedge clk);
        mul_valid    = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        cyc = 1;
        check({nm, "_ready_busy"}, {63'd0, mul_ready}, 64'd0);
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({nm, "_result"}, result, ref_mul(a, b));
        check({nm, "_latency"}, 64'(cyc), 64'(ref_lat(b)));
        @(negedge clk);
        check({nm, "_pulse_end"}, {63'd0, out_valid}, 64'd0);
        check({nm, "_ready_post"}, {63'd0, mul_ready}, 64'd1);
        check({nm, "_result_hold"}, result, ref_mul(a, b));
    endtask

    task automatic wait_no_pulse(input int n, input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(nm, 64'(seen), 64'd0);
    endtask

    logic [63:0] prev;
    logic [63:0] ra;
    logic [63:0] rb;
    int          flush_dly;

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        mul_valid    = 1'b0;
        flush        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{64'd3, 64'd5, 64'hF, "basic"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "wrap_ones"};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'h0, "wrap_msb"};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, "signed_neg7x6"};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'd0, 64'h0, "b_zero"};
        vecs[5] = '{64'd1, 64'd1, 64'h1, "one_one"};
        vecs[6] = '{64'd0, 64'hDEAD_BEEF_0000_0001, 64'h0, "a_zero"};
        vecs[7] = '{64'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "b_msb"};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {63'd0, mul_ready}, 64'd1);
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            check({vecs[i].name, "_table"}, ref_mul(vecs[i].a, vecs[i].b), vecs[i].exp);
            run_op(vecs[i].a, vecs[i].b, vecs[i].name);
        end

        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 3 == 0) rb = rb >> $urandom_range(63, 1);
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        // Flush mid-operation: no pulse, result keeps the last completed value.
        prev = result;
`ifdef MUL_EARLY_TERM_EN
        flush_dly = 2;
`else
        flush_dly = 10;
`endif
        mul_valid    = 1'b1;
        multiplicand = 64'd10;
        multiplier   = 64'd20;
        @(posedge clk);
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (flush_dly - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {63'd0, mul_ready}, 64'd1);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_result", result, prev);
        wait_no_pulse(70, "flush_no_pulse");
        check("flush_result_late", result, prev);
        run_op(64'd4, 64'd4, "after_flush");

        // Requests while busy are ignored.
        mul_valid    = 1'b1;
        multiplicand = 64'd7;
        multiplier   = 64'd9;
        @(posedge clk);
        @(negedge clk);
        multiplicand = 64'd100;
        multiplier   = 64'd100;
        @(negedge clk);
        mul_valid = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("busy_ign_valid", {63'd0, out_valid}, 64'd1);
            check("busy_ign_result", result, 64'd63);
        end
        @(negedge clk);
        check("busy_ign_ready", {63'd0, mul_ready}, 64'd1);
        wait_no_pulse(70, "busy_ign_no_extra");

        // mul_valid together with flush in IDLE is not accepted.
        prev         = result;
        mul_valid    = 1'b1;
        flush        = 1'b1;
        multiplicand = 64'd11;
        multiplier   = 64'd13;
        @(negedge clk);
        mul_valid = 1'b0;
        flush     = 1'b0;
        check("vf_conflict_ready", {63'd0, mul_ready}, 64'd1);
        wait_no_pulse(70, "vf_conflict_no_pulse");
        check("vf_conflict_result", result, prev);

        // Reset mid-operation (with flush) clears everything.
        mul_valid    = 1'b1;
        multiplicand = 64'd5;
        multiplier   = 64'hFFFF;
        @(posedge clk);
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        check("rst_mid_ready", {63'd0, mul_ready}, 64'd1);
        check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_result", result, 64'd0);
        wait_no_pulse(70, "rst_mid_no_pulse");
        run_op(64'd6, 64'd7, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
